// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stim_pkg
//  Purpose  : Shared types and helpers for the stimulus sequencer:
//             pattern-mode and FSM-state enums, the low-fill vector builder
//             and the per-step hold-length function.
//  Revision : 1.0  initial release
// ============================================================================
package stim_pkg;

    // Pattern selection, latched at run start.
    typedef enum logic [1:0] {
        MODE_RAMP     = 2'd0,
        MODE_HIGHFILL = 2'd1,
        MODE_SOLO     = 2'd2,
        MODE_WALK     = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Upper bound on channel width handled by lowfill(); callers slice the
    // low WIDTH bits of the result.
    localparam int unsigned c_max_width = 256;

    // k ones in the LSBs, with k saturated to w.
    function automatic logic [c_max_width-1:0] lowfill(input int unsigned k,
                                                       input int unsigned w);
        logic [c_max_width-1:0] v;
        int unsigned            n;
        n = (k > w) ? w : k;
        v = '0;
        for (int unsigned i = 0; i < c_max_width; i++) begin
            if (i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Number of cycles step s stays on the outputs.
    function automatic int unsigned hold_cycles(input int unsigned s,
                                                input int unsigned base,
                                                input int unsigned inc);
        return base + s * inc;
    endfunction

endpackage : stim_pkg
`default_nettype wire

// File: rtl/stim_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : stim_pattern_gen
//  Purpose  : Combinational pattern builder. Produces the flat vector of all
//             channels for a given mode and step.
//  Ports    : i_mode  - pattern mode
//             i_step  - schedule step
//             o_vec   - CHANNELS*WIDTH flat vector, channel c at [c*WIDTH +: WIDTH]
//  Revision : 1.0  initial release
// ============================================================================
module stim_pattern_gen
    import stim_pkg::*;
#(
    parameter int WIDTH    = 17,
    parameter int CHANNELS = 6,
    parameter int STEP_W   = 3
) (
    input  mode_t                       i_mode,
    input  logic [STEP_W-1:0]           i_step,
    output logic [CHANNELS*WIDTH-1:0]   o_vec
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] w_vec;

        always_comb begin
            int unsigned              k;
            int unsigned              sat_k;
            logic [c_max_width-1:0]   fill;
            k     = 32'(i_step) + 32'(c) + 32'd1;
            sat_k = (k > 32'(WIDTH)) ? 32'(WIDTH) : k;
            fill  = '0;
            w_vec = '0;
            case (i_mode)
                MODE_RAMP: begin
                    fill  = lowfill(k, 32'(WIDTH));
                    w_vec = fill[WIDTH-1:0];
                end
                MODE_HIGHFILL: begin
                    // Top sat_k bits set = complement of the remaining low fill.
                    fill  = lowfill(32'(WIDTH) - sat_k, 32'(WIDTH));
                    w_vec = ~fill[WIDTH-1:0];
                end
                MODE_SOLO: begin
                    w_vec = ((32'(i_step) % 32'(CHANNELS)) == 32'(c)) ? '1 : '0;
                end
                MODE_WALK: begin
                    w_vec = {{(WIDTH-1){1'b0}}, 1'b1} << ((k - 32'd1) % 32'(WIDTH));
                end
                default: begin
                    w_vec = '0;
                end
            endcase
        end

        assign o_vec[c*WIDTH +: WIDTH] = w_vec;
    end

endmodule : stim_pattern_gen
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stim_sequencer
//  Purpose  : Drives CHANNELS parallel WIDTH-bit stimulus vectors through a
//             STEPS-long schedule; step s is held HOLD_BASE + s*HOLD_INC
//             cycles. Supports pattern modes, looping, abort and a done pulse.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             start      - begin a run (IDLE only)
//             abort      - terminate run / clear outputs; wins over start
//             mode       - pattern mode, latched on accepted start
//             loop_en    - repeat schedule, latched on accepted start
//             stim       - flat vectors, channel c at [c*WIDTH +: WIDTH]
//             step_idx   - current step
//             stim_valid - one-cycle pulse when a new vector is loaded
//             busy       - run in progress
//             done       - one-cycle pulse at normal completion
//  Revision : 1.0  initial release
// ============================================================================
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int WIDTH     = 17,
    parameter int CHANNELS  = 6,
    parameter int STEPS     = 8,
    parameter int HOLD_BASE = 2,
    parameter int HOLD_INC  = 2,
    localparam int STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int HOLD_W   = $clog2(hold_cycles(32'(STEPS - 1), 32'(HOLD_BASE),
                                                 32'(HOLD_INC)) + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [1:0]                  mode,
    input  logic                        loop_en,
    output logic [CHANNELS*WIDTH-1:0]   stim,
    output logic [STEP_W-1:0]           step_idx,
    output logic                        stim_valid,
    output logic                        busy,
    output logic                        done
);

    state_t                     r_state;
    mode_t                      r_mode;
    logic                       r_loop;
    logic [STEP_W-1:0]          r_step;
    logic [HOLD_W-1:0]          r_hold;
    logic [CHANNELS*WIDTH-1:0]  r_stim;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_last;
    logic [STEP_W-1:0]          w_next_step;
    logic [HOLD_W-1:0]          w_next_hold;
    mode_t                      w_gen_mode;
    logic [CHANNELS*WIDTH-1:0]  w_pat;

    // One generator serves both the start load and the step advance: in IDLE
    // it sees the live mode input (not yet latched), in RUN the latched mode.
    always_comb begin
        w_last     = (r_step == STEP_W'(STEPS - 1));
        w_gen_mode = (r_state == ST_IDLE) ? mode_t'(mode) : r_mode;
        if ((r_state == ST_IDLE) || w_last) begin
            w_next_step = '0;
        end else begin
            w_next_step = r_step + STEP_W'(1);
        end
        // Counter is loaded with HOLD-1 so the vector is visible HOLD cycles.
        w_next_hold = HOLD_W'(hold_cycles(32'(w_next_step), 32'(HOLD_BASE),
                                          32'(HOLD_INC)) - 32'd1);
    end

    stim_pattern_gen #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STEP_W   (STEP_W)
    ) u_pattern_gen (
        .i_mode (w_gen_mode),
        .i_step (w_next_step),
        .o_vec  (w_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_RAMP;
            r_loop  <= 1'b0;
            r_step  <= '0;
            r_hold  <= '0;
            r_stim  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (abort) begin
                        r_stim <= '0;
                        r_step <= '0;
                    end else if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_step  <= w_next_step;
                        r_stim  <= w_pat;
                        r_hold  <= w_next_hold;
                        r_valid <= 1'b1;
                        r_mode  <= mode_t'(mode);
                        r_loop  <= loop_en;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_stim  <= '0;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end else if (!w_last || r_loop) begin
                        // Advance, or wrap to step 0 when looping.
                        r_step  <= w_next_step;
                        r_stim  <= w_pat;
                        r_hold  <= w_next_hold;
                        r_valid <= 1'b1;
                    end else begin
                        // Last vector stays on stim until next start/abort/reset.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim       = r_stim;
    assign step_idx   = r_step;
    assign stim_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : stim_sequencer
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stim_sequencer
//  Purpose  : Directed self-checking bench for stim_sequencer (default
//             parameters plus a STEPS=20 instance for walk wrap-around).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stim_sequencer;

    localparam int W  = 17;
    localparam int CH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, abort, loop_en;
    logic [1:0]        mode;
    logic [CH*W-1:0]   stim;
    logic [2:0]        step_idx;
    logic              stim_valid, busy, done;

    logic              start20, abort20, loop20;
    logic [1:0]        mode20;
    logic [CH*W-1:0]   stim20;
    logic [4:0]        step20;
    logic              valid20, busy20, done20;

    int n_chk = 0;
    int n_bad = 0;

    stim_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .loop_en    (loop_en),
        .stim       (stim),
        .step_idx   (step_idx),
        .stim_valid (stim_valid),
        .busy       (busy),
        .done       (done)
    );

    stim_sequencer #(.STEPS(20)) u_dut20 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start20),
        .abort      (abort20),
        .mode       (mode20),
        .loop_en    (loop20),
        .stim       (stim20),
        .step_idx   (step20),
        .stim_valid (valid20),
        .busy       (busy20),
        .done       (done20)
    );

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ch(input logic [CH*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    initial begin
        logic [CH*W-1:0] e;
        int              cnt;
        int              dcnt;
        logic            found;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; loop_en = 1'b0;
        start20 = 1'b0; abort20 = 1'b0; mode20 = 2'd0; loop20 = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_stim",  stim, 0);
        check_val("rst_step",  step_idx, 0);
        check_val("rst_valid", stim_valid, 0);
        check_val("rst_busy",  busy, 0);
        check_val("rst_done",  done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- mode 0 full run ----
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0) begin
                check_val("r0_v0",   stim_valid, 1);
                check_val("r0_ch0",  ch(stim, 0), 17'h00001);
                check_val("r0_ch5",  ch(stim, 5), 17'h0003F);
            end
            if (i == 1) begin
                check_val("r0_v1",   stim_valid, 0);
                check_val("r0_hold", ch(stim, 0), 17'h00001);
            end
            if (i == 2) begin
                check_val("r1_step", step_idx, 1);
                check_val("r1_v",    stim_valid, 1);
                check_val("r1_ch0",  ch(stim, 0), 17'h00003);
            end
            if (i == 5) check_val("r1_hold", ch(stim, 0), 17'h00003);
            if (i == 6) check_val("r2_step", step_idx, 2);
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
        check_val("r0_busycyc", cnt, 72);
        check_val("r0_done",    done, 1);
        check_val("r0_lastch0", ch(stim, 0), 17'h000FF);
        @(negedge clk);
        check_val("r0_done_end", done, 0);
        check_val("r0_keep",     ch(stim, 0), 17'h000FF);

        // ---- mode 2 (SOLO) run ----
        mode = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (step_idx == 3'd3 && stim_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check_val("m2_s3_seen", found, 1);
        e = '0; e[3*W +: W] = '1;
        check_val("m2_s3", stim, e);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (step_idx == 3'd6 && stim_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check_val("m2_s6_seen", found, 1);
        e = '0; e[0 +: W] = '1;
        check_val("m2_s6", stim, e);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check_val("m2_end_seen", found, 1);
        e = '0; e[1*W +: W] = '1;
        check_val("m2_last", stim, e);

        // ---- start together with abort in IDLE ----
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_val("sa_busy",  busy, 0);
        check_val("sa_stim",  stim, 0);
        check_val("sa_valid", stim_valid, 0);
        @(negedge clk);
        check_val("sa_busy2", busy, 0);

        // ---- mode 1 step 0 ----
        mode = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("m1_ch0", ch(stim, 0), 17'h10000);
        check_val("m1_ch5", ch(stim, 5), 17'h1F800);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("m1_abort_busy", busy, 0);

        // ---- abort in step 3 of mode 0 ----
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (step_idx == 3'd3 && stim_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check_val("ab_seen", found, 1);
        check_val("ab_ch0",  ch(stim, 0), 17'h0000F);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("ab_stim",  stim, 0);
        check_val("ab_busy",  busy, 0);
        check_val("ab_step",  step_idx, 0);
        check_val("ab_done",  done, 0);
        check_val("ab_valid", stim_valid, 0);

        // ---- looping run with a stray start mid-run ----
        mode = 2'd0; loop_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; loop_en = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 151; i++) begin
            if (done) dcnt++;
            if (i == 11) begin
                check_val("lp_ign_step",  step_idx, 2);
                check_val("lp_ign_ch0",   ch(stim, 0), 17'h00007);
                check_val("lp_ign_valid", stim_valid, 0);
                start = 1'b0; mode = 2'd0;
            end
            if (i == 72) begin
                check_val("lp72_step",  step_idx, 0);
                check_val("lp72_valid", stim_valid, 1);
                check_val("lp72_ch0",   ch(stim, 0), 17'h00001);
            end
            if (i == 144) begin
                check_val("lp144_step",  step_idx, 0);
                check_val("lp144_valid", stim_valid, 1);
            end
            if (i == 10) begin
                start = 1'b1; mode = 2'd3;
            end
            if (i < 150) @(negedge clk);
        end
        check_val("lp_nodone", dcnt, 0);
        check_val("lp_busy",   busy, 1);

        // ---- asynchronous reset mid-hold ----
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_stim",  stim, 0);
        check_val("ar_step",  step_idx, 0);
        check_val("ar_valid", stim_valid, 0);
        check_val("ar_busy",  busy, 0);
        check_val("ar_done",  done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- STEPS=20 walk wrap ----
        mode20 = 2'd3; start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (step20 == 5'd16 && valid20) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check_val("w20_seen", found, 1);
        check_val("w20_ch1",  ch(stim20, 1), 17'h00001);
        check_val("w20_ch0",  ch(stim20, 0), 17'h10000);
        abort20 = 1'b1;
        @(negedge clk);
        abort20 = 1'b0;
        check_val("w20_abort", busy20, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_stim_sequencer
`default_nettype wire
